// File: rtl/regfile_pkg.sv
// Shared defaults, constants and write-port selection for the register-file access controller.
package regfile_pkg;

    localparam int DATA_SIZE_DEFAULT      = 32;
    localparam int RAM_DEPTH_LOG2_DEFAULT = 5;
    localparam int REG_ZERO               = 0;

    typedef struct packed {
        logic wr1;
        logic wr2;
    } wr_sel_t;

    // wb2 is younger in program order, so it owns a shared address; x0 writes are never issued.
    function automatic wr_sel_t write_select(
        input logic wb1_valid,
        input logic wb1_is_zero,
        input logic wb2_valid,
        input logic wb2_is_zero,
        input logic same_addr
    );
        wr_sel_t sel;
        sel.wr2 = wb2_valid & ~wb2_is_zero;
        sel.wr1 = wb1_valid & ~wb1_is_zero & ~(sel.wr2 & same_addr);
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard: one busy bit per register, x0 never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int RAM_DEPTH_LOG2 = RAM_DEPTH_LOG2_DEFAULT
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            set_en,
    input  logic [RAM_DEPTH_LOG2-1:0]       set_idx,
    input  logic                            clr1_en,
    input  logic [RAM_DEPTH_LOG2-1:0]       clr1_idx,
    input  logic                            clr2_en,
    input  logic [RAM_DEPTH_LOG2-1:0]       clr2_idx,
    input  logic [RAM_DEPTH_LOG2-1:0]       rs1_idx,
    input  logic [RAM_DEPTH_LOG2-1:0]       rs2_idx,
    input  logic [RAM_DEPTH_LOG2-1:0]       rd_idx,
    output logic                            rs1_busy,
    output logic                            rs2_busy,
    output logic                            rd_busy,
    output logic [2**RAM_DEPTH_LOG2-1:0]    busy_vec
);

    logic [2**RAM_DEPTH_LOG2-1:0] busy_q;
    logic [2**RAM_DEPTH_LOG2-1:0] busy_nxt;

    // Clears are applied before the set so an issuing instruction keeps its bit.
    always_comb begin
        // NOTE: start from the held value so every path assigns busy_nxt and no latch is inferred.
        busy_nxt = busy_q;
        if (clr1_en) busy_nxt[clr1_idx] = 1'b0;
        if (clr2_en) busy_nxt[clr2_idx] = 1'b0;
        if (set_en)  busy_nxt[set_idx]  = 1'b1;
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            busy_q <= busy_nxt;
        end
    end

    assign rs1_busy = busy_q[rs1_idx];
    assign rs2_busy = busy_q[rs2_idx];
    assign rd_busy  = busy_q[rd_idx];
    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: hazard gating, 2R2W RAM steering, x0 handling, writeback forwarding.
// Optional macro REGFILE_BYPASS_EN enables same-cycle writeback forwarding instead of stalling.
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_SIZE      = DATA_SIZE_DEFAULT,
    parameter int RAM_DEPTH_LOG2 = RAM_DEPTH_LOG2_DEFAULT
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [RAM_DEPTH_LOG2-1:0]       req_rs1,
    input  logic [RAM_DEPTH_LOG2-1:0]       req_rs2,
    input  logic [RAM_DEPTH_LOG2-1:0]       req_rd,
    input  logic                            req_rd_en,
    output logic                            rsp_valid,
    output logic [DATA_SIZE-1:0]            rsp_rs1_data,
    output logic [DATA_SIZE-1:0]            rsp_rs2_data,
    input  logic                            wb1_valid,
    input  logic [RAM_DEPTH_LOG2-1:0]       wb1_addr,
    input  logic [DATA_SIZE-1:0]            wb1_data,
    input  logic                            wb2_valid,
    input  logic [RAM_DEPTH_LOG2-1:0]       wb2_addr,
    input  logic [DATA_SIZE-1:0]            wb2_data,
    output logic                            ram_rden1,
    output logic                            ram_rden2,
    output logic                            ram_wren1,
    output logic                            ram_wren2,
    output logic [RAM_DEPTH_LOG2-1:0]       ram_addr1rd,
    output logic [RAM_DEPTH_LOG2-1:0]       ram_addr2rd,
    output logic [RAM_DEPTH_LOG2-1:0]       ram_addr1wr,
    output logic [RAM_DEPTH_LOG2-1:0]       ram_addr2wr,
    output logic [DATA_SIZE-1:0]            ram_data_in1,
    output logic [DATA_SIZE-1:0]            ram_data_in2,
    input  logic [DATA_SIZE-1:0]            ram_data_out1,
    input  logic [DATA_SIZE-1:0]            ram_data_out2,
    output logic [2**RAM_DEPTH_LOG2-1:0]    busy_vec
);

    localparam logic [RAM_DEPTH_LOG2-1:0] ZERO_IDX = RAM_DEPTH_LOG2'(REG_ZERO);

    wr_sel_t wsel;
    logic    rs1_nz, rs2_nz;
    logic    rs1_hit1, rs1_hit2, rs2_hit1, rs2_hit2, rs1_hit, rs2_hit;
    logic    rs1_busy, rs2_busy, rd_busy;
    logic    src_hazard, accept;
    logic    rsp_valid_q, rs1_zero_q, rs2_zero_q;
    logic [DATA_SIZE-1:0] rs1_val, rs2_val;

    // Writebacks are masked during reset so the RAM sees no enables.
    assign wsel = write_select(wb1_valid & reset_n, wb1_addr == ZERO_IDX,
                               wb2_valid & reset_n, wb2_addr == ZERO_IDX,
                               wb1_addr == wb2_addr);

    assign rs1_nz   = (req_rs1 != ZERO_IDX);
    assign rs2_nz   = (req_rs2 != ZERO_IDX);
    assign rs1_hit1 = wsel.wr1 & (wb1_addr == req_rs1);
    assign rs1_hit2 = wsel.wr2 & (wb2_addr == req_rs1);
    assign rs2_hit1 = wsel.wr1 & (wb1_addr == req_rs2);
    assign rs2_hit2 = wsel.wr2 & (wb2_addr == req_rs2);
    assign rs1_hit  = rs1_nz & (rs1_hit1 | rs1_hit2);
    assign rs2_hit  = rs2_nz & (rs2_hit1 | rs2_hit2);

`ifdef REGFILE_BYPASS_EN
    assign src_hazard = (rs1_nz & rs1_busy & ~rs1_hit) | (rs2_nz & rs2_busy & ~rs2_hit);
`else
    // Without forwarding, a same-cycle write to a source must land in the RAM first.
    assign src_hazard = (rs1_nz & (rs1_busy | rs1_hit)) | (rs2_nz & (rs2_busy | rs2_hit));
`endif

    assign req_ready = reset_n & ~src_hazard & ~(req_rd_en & rd_busy);
    assign accept    = req_valid & req_ready;

    regfile_scoreboard #(.RAM_DEPTH_LOG2(RAM_DEPTH_LOG2)) u_scoreboard (
        .clock    (clock),
        .reset_n  (reset_n),
        .set_en   (accept & req_rd_en & (req_rd != ZERO_IDX)),
        .set_idx  (req_rd),
        .clr1_en  (wsel.wr1),
        .clr1_idx (wb1_addr),
        .clr2_en  (wsel.wr2),
        .clr2_idx (wb2_addr),
        .rs1_idx  (req_rs1),
        .rs2_idx  (req_rs2),
        .rd_idx   (req_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec)
    );

    assign ram_rden1    = accept;
    assign ram_rden2    = accept;
    assign ram_addr1rd  = accept ? req_rs1 : '0;
    assign ram_addr2rd  = accept ? req_rs2 : '0;
    assign ram_wren1    = wsel.wr1;
    assign ram_wren2    = wsel.wr2;
    assign ram_addr1wr  = wsel.wr1 ? wb1_addr : '0;
    assign ram_addr2wr  = wsel.wr2 ? wb2_addr : '0;
    assign ram_data_in1 = wsel.wr1 ? wb1_data : '0;
    assign ram_data_in2 = wsel.wr2 ? wb2_data : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rs1_zero_q  <= 1'b0;
            rs2_zero_q  <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rs1_zero_q <= ~rs1_nz;
                rs2_zero_q <= ~rs2_nz;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic                 byp1_q, byp2_q;
    logic [DATA_SIZE-1:0] byp1_data_q, byp2_data_q;

    // The RAM returns pre-write data on a read/write collision, so capture the write value here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byp1_q      <= 1'b0;
            byp2_q      <= 1'b0;
            byp1_data_q <= '0;
            byp2_data_q <= '0;
        end else if (accept) begin
            byp1_q      <= rs1_hit;
            byp2_q      <= rs2_hit;
            byp1_data_q <= rs1_hit2 ? wb2_data : wb1_data;
            byp2_data_q <= rs2_hit2 ? wb2_data : wb1_data;
        end
    end

    assign rs1_val = rs1_zero_q ? '0 : (byp1_q ? byp1_data_q : ram_data_out1);
    assign rs2_val = rs2_zero_q ? '0 : (byp2_q ? byp2_data_q : ram_data_out2);
`else
    assign rs1_val = rs1_zero_q ? '0 : ram_data_out1;
    assign rs2_val = rs2_zero_q ? '0 : ram_data_out2;
`endif

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rs1_data = rsp_valid_q ? rs1_val : '0;
    assign rsp_rs2_data = rsp_valid_q ? rs2_val : '0;

endmodule
